// File: rtl/tcm_stream_preloader_if.sv
// Purpose: byte-stream and TCM RAM write-port signal bundle for the preloader.
// Latency: none; wires only.
// Backpressure: s_valid/s_ready handshake on the stream; the RAM port has no ready.
// Signals: s_valid/s_ready/s_data/s_last carry the little-endian image bytes;
//          ram_cs/ram_we/ram_wem/ram_addr/ram_din drive a 1-cycle synchronous RAM write.
// slave = preloader side, master = stream source / RAM model side.
interface tcm_stream_preloader_if #(
    parameter int DW = 64,
    parameter int AW = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic              ram_cs;
    logic              ram_we;
    logic [DW/8-1:0]   ram_wem;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, ram_cs, ram_we, ram_wem, ram_addr, ram_din
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, ram_cs, ram_we, ram_wem, ram_addr, ram_din
    );
endinterface

// File: rtl/tcm_stream_preloader.sv
// Purpose: packs a little-endian byte stream into DW-bit TCM words, writes them from
//          address 0 upward, and holds the core in reset until the image is loaded.
// Latency: DW/8 bytes per DW/8+1 cycles; one WRITE cycle after each full/last word.
// Backpressure: s_ready is low in IDLE, WRITE and DONE; source gaps simply stall FILL.
// Ports: clk, rst (sync, active high); i_start pulse begins a load at word 0;
//        bus (slave modport) = byte stream in + RAM write port out;
//        o_core_rst_n (1 only in DONE), o_busy, o_done, o_err_ovf, o_words_written.
module tcm_stream_preloader #(
    parameter int DW    = 64,
    parameter int AW    = 16,
    parameter int DEPTH = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    tcm_stream_preloader_if.slave bus,
    output logic                  o_core_rst_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err_ovf,
    output logic [AW:0]           o_words_written
);
    localparam int LANES = DW / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LP_LAST_LANE = LW'(LANES - 1);
    // One extra bit so DEPTH == 2^AW is representable in the range compare.
    localparam logic [AW:0]   LP_DEPTH     = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [DW-1:0]    r_buf;
    logic [LANES-1:0] r_mask;
    logic [LW-1:0]    r_lane;
    logic             r_last;
    logic [AW:0]      r_addr;     // next word address; also the count of writes issued
    logic             r_err;
    logic             r_core_rst_n;
    logic             r_busy;
    logic             r_done;

    logic             w_s_ready;
    logic             w_ram_cs;
    logic             w_accept;
    logic             w_in_range;

    assign w_accept   = bus.s_valid & w_s_ready;
    assign w_in_range = (r_addr < LP_DEPTH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/RAM strobes
    always_comb begin
        w_next    = r_state;
        w_s_ready = 1'b0;
        w_ram_cs  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_FILL;
            end
            S_FILL: begin
                w_s_ready = 1'b1;
                if (bus.s_valid && ((r_lane == LP_LAST_LANE) || bus.s_last)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_ram_cs = w_in_range;
                // An out-of-range word means the image overflowed; the rest is discarded.
                if (r_last)            w_next = S_DONE;
                else if (!w_in_range)  w_next = S_DRAIN;
                else                   w_next = S_FILL;
            end
            S_DRAIN: begin
                w_s_ready = 1'b1;
                if (bus.s_valid && bus.s_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (i_start) w_next = S_FILL;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Packing datapath, address counter and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf  <= '0;
            r_mask <= '0;
            r_lane <= '0;
            r_last <= 1'b0;
            r_addr <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_buf  <= '0;
                        r_mask <= '0;
                        r_lane <= '0;
                        r_last <= 1'b0;
                        r_addr <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_buf[8*r_lane +: 8] <= bus.s_data;
                        r_mask[r_lane]       <= 1'b1;
                        r_lane               <= r_lane + 1'b1;
                        r_last               <= bus.s_last;
                    end
                end
                S_WRITE: begin
                    if (w_in_range) r_addr <= r_addr + 1'b1;
                    else            r_err  <= 1'b1;
                    r_buf  <= '0;
                    r_mask <= '0;
                    r_lane <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Status flops follow the state the FSM is entering, so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_core_rst_n <= (w_next == S_DONE);
            r_done       <= (w_next == S_DONE);
            r_busy       <= (w_next == S_FILL) || (w_next == S_WRITE) || (w_next == S_DRAIN);
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.ram_cs   = w_ram_cs;
    assign bus.ram_we   = w_ram_cs;
    assign bus.ram_wem  = w_ram_cs ? r_mask : '0;
    assign bus.ram_addr = w_ram_cs ? r_addr[AW-1:0] : '0;
    assign bus.ram_din  = w_ram_cs ? r_buf : '0;

    assign o_core_rst_n    = r_core_rst_n;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err_ovf       = r_err;
    assign o_words_written = r_addr;
endmodule
